// File: rtl/intercal_pkg.sv
// intercal_pkg
// Shared definitions for the INTERCAL inverse-operation engine:
//   INTERCAL_WIDTH      - operand width (only 32 is supported)
//   intercal_inv_op_t   - inverse operation encoding, matches the op port
//   intercal_inv_state_t- sequencer states of intercal_unalu
package intercal_pkg;

  localparam int INTERCAL_WIDTH = 32;

  typedef enum logic [1:0] {
    UNMINGLE  = 2'b00,
    DEPOSIT32 = 2'b01,
    DEPOSIT16 = 2'b10,
    UNXOR32   = 2'b11
  } intercal_inv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } intercal_inv_state_t;

endpackage

// File: rtl/intercal_inv_bitstep.sv
// intercal_inv_bitstep
// Combinational single-bit step of the inverse operations. Given the current
// bit counter and deposit pointer it produces one result bit, the result index
// it belongs to, and the updated deposit pointer.
// Ports:
//   i_op      operation (intercal_inv_op_t encoding)
//   i_cnt     bit currently being processed (0..31)
//   i_k       deposit source pointer
//   i_a, i_b  latched data / mask operands
//   i_r_prev  previous result bit r[cnt-1] (unxor32 chain)
//   o_bit     next result bit
//   o_idx     result bit index to write
//   o_k_next  updated deposit pointer
module intercal_inv_bitstep
  import intercal_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [4:0]  i_cnt,
  input  logic [4:0]  i_k,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_r_prev,
  output logic        o_bit,
  output logic [4:0]  o_idx,
  output logic [4:0]  o_k_next
);

  logic [4:0] w_cnt_m1;
  logic [4:0] w_k_eff;
  logic [4:0] w_src16;

  assign w_cnt_m1 = i_cnt - 5'd1;
  // deposit16 restarts the pointer at the half boundary; upper half reads a[16+k]
  assign w_k_eff  = (i_cnt == 5'd16) ? 5'd0 : i_k;
  assign w_src16  = {i_cnt[4], w_k_eff[3:0]};

  always_comb begin
    o_bit    = 1'b0;
    o_idx    = i_cnt;
    o_k_next = i_k;
    case (intercal_inv_op_t'(i_op))
      UNMINGLE: begin
        // input bit cnt: even bits fill the low half, odd bits the high half
        o_bit = i_a[i_cnt];
        o_idx = {i_cnt[0], i_cnt[4:1]};
      end
      DEPOSIT32: begin
        if (i_b[i_cnt]) begin
          o_bit    = i_a[i_k];
          o_k_next = i_k + 5'd1;
        end
      end
      DEPOSIT16: begin
        o_k_next = w_k_eff;
        if (i_b[i_cnt]) begin
          o_bit    = i_a[w_src16];
          o_k_next = w_k_eff + 5'd1;
        end
      end
      UNXOR32: begin
        // r[0] is fixed at 0; the complementary solution is the other inverse
        o_bit = (i_cnt == 5'd0) ? 1'b0 : (i_a[w_cnt_m1] ^ i_r_prev);
      end
    endcase
  end

endmodule

// File: rtl/intercal_unalu.sv
// intercal_unalu
// Sequential inverse-operation engine: accepts one operand pair, undoes
// unmingle / deposit32 / deposit16 / unxor32 one bit per cycle over 32 cycles,
// then presents the result until the consumer takes it.
// Ports:
//   clk, rst                 clock, async active-high reset
//   i_op, i_a, i_b           operation and operands, sampled on input handshake
//   i_in_valid / o_in_ready  input handshake
//   o_f, o_err               result, unxor32 no-inverse flag
//   o_out_valid / i_out_ready output handshake
// WIDTH is fixed at 32; the bit-step datapath is hardwired to it.
module intercal_unalu
  import intercal_pkg::*;
#(
  parameter int WIDTH = INTERCAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_f,
  output logic             o_err,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  intercal_inv_state_t r_state;
  logic [1:0]          r_op;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [4:0]          r_cnt;
  logic [4:0]          r_k;
  logic [WIDTH-1:0]    r_f;
  logic                r_err;

  logic                w_bit;
  logic [4:0]          w_idx;
  logic [4:0]          w_k_next;
  logic [4:0]          w_cnt_m1;

  assign w_cnt_m1 = r_cnt - 5'd1;

  intercal_inv_bitstep u_bitstep (
    .i_op     (r_op),
    .i_cnt    (r_cnt),
    .i_k      (r_k),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_r_prev (r_f[w_cnt_m1]),
    .o_bit    (w_bit),
    .o_idx    (w_idx),
    .o_k_next (w_k_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= 2'b00;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= 5'd0;
      r_k     <= 5'd0;
      r_f     <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_op    <= i_op;
            r_a     <= i_a;
            r_b     <= i_b;
            r_cnt   <= 5'd0;
            r_k     <= 5'd0;
            r_f     <= '0;
            r_err   <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_f[w_idx] <= w_bit;
          r_k        <= w_k_next;
          r_cnt      <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= ST_DONE;
            // odd parity of a leaves no inverse; w_bit is r[31] here
            if (intercal_inv_op_t'(r_op) == UNXOR32)
              r_err <= r_a[31] ^ r_f[0] ^ w_bit;
          end
        end
        ST_DONE: begin
          if (i_out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE) & ~rst;
  assign o_out_valid = (r_state == ST_DONE);
  assign o_f         = r_f;
  assign o_err       = r_err;

endmodule

// File: tb/tb_intercal_unalu.sv
module tb_intercal_unalu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] f;
  logic        err;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  intercal_unalu dut (
    .clk         (clk),
    .rst         (rst),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_f         (f),
    .o_err       (err),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] sel(input logic [31:0] x, input logic [31:0] m);
    logic [31:0] r;
    int j;
    r = '0;
    j = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
        r[j] = x[i];
        j++;
      end
    end
    return r;
  endfunction

  // Present one operand set for a single edge, then scramble the operands.
  task automatic start_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb);
    @(negedge clk);
    op = o; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~o; a = ~xa; b = ~xb;
  endtask

  // Count edges until out_valid; n = -1 on timeout.
  task automatic wait_done(output int n, output bit rdy_hi);
    int cnt;
    cnt = 0;
    rdy_hi = 1'b0;
    n = -1;
    while (cnt < 40) begin
      @(posedge clk);
      cnt++;
      #1;
      if (out_valid) begin
        n = cnt;
        break;
      end
      if (in_ready) rdy_hi = 1'b1;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (f !== 32'h0) begin failures++; $display("FAIL reset_f got=%h exp=00000000", f); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_unmingle();
    int n; bit rh;
    start_op(2'b00, 32'hAAAAAAAA, 32'h12345678);
    wait_done(n, rh);
    checks++; if (n !== 32) begin failures++; $display("FAIL unmingle_latency got=%0d exp=32", n); end
    checks++; if (rh !== 1'b0) begin failures++; $display("FAIL unmingle_in_ready_busy got=%b exp=0", rh); end
    checks++; if (f !== 32'hFFFF0000) begin failures++; $display("FAIL unmingle_f got=%h exp=FFFF0000", f); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL unmingle_err got=%b exp=0", err); end
    finish_op();
    start_op(2'b00, 32'h55555555, 32'h0);
    wait_done(n, rh);
    checks++; if (f !== 32'h0000FFFF) begin failures++; $display("FAIL unmingle2_f got=%h exp=0000FFFF", f); end
    finish_op();
    start_op(2'b00, 32'h0000000F, 32'h0);
    wait_done(n, rh);
    checks++; if (f !== 32'h00030003) begin failures++; $display("FAIL unmingle3_f got=%h exp=00030003", f); end
    finish_op();
  endtask

  task automatic test_deposit32();
    int n; bit rh;
    start_op(2'b01, 32'h00000005, 32'h80808080);
    wait_done(n, rh);
    checks++; if (n !== 32) begin failures++; $display("FAIL dep32_latency got=%0d exp=32", n); end
    checks++; if (f !== 32'h00800080) begin failures++; $display("FAIL dep32_f got=%h exp=00800080", f); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL dep32_err got=%b exp=0", err); end
    checks++; if (sel(f, 32'h80808080) !== 32'h5) begin failures++; $display("FAIL dep32_select got=%h exp=00000005", sel(f, 32'h80808080)); end
    finish_op();
  endtask

  task automatic test_deposit16();
    int n; bit rh;
    start_op(2'b10, 32'h00030003, 32'h000F00F0);
    wait_done(n, rh);
    checks++; if (n !== 32) begin failures++; $display("FAIL dep16_latency got=%0d exp=32", n); end
    checks++; if (f !== 32'h00030030) begin failures++; $display("FAIL dep16_f got=%h exp=00030030", f); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL dep16_err got=%b exp=0", err); end
    finish_op();
  endtask

  task automatic test_unxor();
    int n; bit rh;
    start_op(2'b11, 32'h80000001, 32'h0);
    wait_done(n, rh);
    checks++; if (n !== 32) begin failures++; $display("FAIL unxor_latency got=%0d exp=32", n); end
    checks++; if (f !== 32'hFFFFFFFE) begin failures++; $display("FAIL unxor1_f got=%h exp=FFFFFFFE", f); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL unxor1_err got=%b exp=0", err); end
    finish_op();
    start_op(2'b11, 32'h00000001, 32'h0);
    wait_done(n, rh);
    checks++; if (f !== 32'hFFFFFFFE) begin failures++; $display("FAIL unxor2_f got=%h exp=FFFFFFFE", f); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL unxor2_err got=%b exp=1", err); end
    finish_op();
    start_op(2'b11, 32'hFFFFFFFF, 32'h0);
    wait_done(n, rh);
    checks++; if (f !== 32'hAAAAAAAA) begin failures++; $display("FAIL unxor3_f got=%h exp=AAAAAAAA", f); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL unxor3_err got=%b exp=0", err); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int n; bit rh;
    start_op(2'b11, 32'h80000001, 32'h0);
    wait_done(n, rh);
    checks++; if (n !== 32) begin failures++; $display("FAIL bp_latency got=%0d exp=32", n); end
    // offer a new operand while DONE; it must not be taken yet
    op = 2'b01; a = 32'h00000005; b = 32'h80808080; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++; if (f !== 32'hFFFFFFFE) begin failures++; $display("FAIL bp_f_stable cyc=%0d got=%h exp=FFFFFFFE", i, f); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept_in_ready got=%b exp=0", in_ready); end
    wait_done(n, rh);
    checks++; if (n !== 32) begin failures++; $display("FAIL bp_next_latency got=%0d exp=32", n); end
    checks++; if (f !== 32'h00800080) begin failures++; $display("FAIL bp_next_f got=%h exp=00800080", f); end
    finish_op();
  endtask

  task automatic test_reset_mid_run();
    int n; bit rh;
    start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (15) @(posedge clk);
    #1;
    checks++; if (f !== 32'h00007FFF) begin failures++; $display("FAIL rstrun_partial_f got=%h exp=00007FFF", f); end
    rst = 1'b1;
    #1;
    checks++; if (f !== 32'h0) begin failures++; $display("FAIL rstrun_f got=%h exp=00000000", f); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstrun_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstrun_in_ready got=%b exp=0", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_op(2'b01, 32'h00000005, 32'h80808080);
    wait_done(n, rh);
    checks++; if (n !== 32) begin failures++; $display("FAIL rstrun_next_latency got=%0d exp=32", n); end
    checks++; if (f !== 32'h00800080) begin failures++; $display("FAIL rstrun_next_f got=%h exp=00800080", f); end
    // reset while DONE drops out_valid without a clock edge
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstdone_out_valid got=%b exp=0", out_valid); end
    checks++; if (f !== 32'h0) begin failures++; $display("FAIL rstdone_f got=%h exp=00000000", f); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstdone_in_ready got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_unmingle();
    test_deposit32();
    test_deposit16();
    test_unxor();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
